// File: rtl/riscv_muldiv_unit_if.sv
// riscv_muldiv_unit_if: request / write-back bundle between issue logic and
// the iterative RV32M multiply/divide unit.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_addr,
        input  busy, done, wb_en, wb_rd, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_addr,
        output busy, done, wb_en, wb_rd, result
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M execute unit, shift-add multiply and
// restoring divide at one bit per clock, sign fix-up on sign-magnitude.
module riscv_muldiv_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input logic                clock,
    input logic                reset,
    riscv_muldiv_unit_if.slave bus
);
    if (XLEN != 32) begin : g_xlen_check
        $error("riscv_muldiv_unit supports XLEN=32 only");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_neg;
    logic [XLEN-1:0]   r_opd;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_acc;

    logic              w_is_div;
    logic              w_is_rem;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN-1:0]   w_res;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_dshift;
    logic [XLEN:0]     w_ddiff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_is_div   = bus.funct3[2];
    assign w_is_rem   = bus.funct3[2] & bus.funct3[1];
    assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)
                     || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100)
                     || (bus.funct3 == 3'b110);
    assign w_sa       = w_a_signed & bus.rs1_data[XLEN-1];
    assign w_sb       = w_b_signed & bus.rs2_data[XLEN-1];
    assign w_abs_a    = w_sa ? -bus.rs1_data : bus.rs1_data;
    assign w_abs_b    = w_sb ? -bus.rs2_data : bus.rs2_data;
    assign w_div0     = w_is_div && (bus.rs2_data == '0);
    assign w_ovf      = w_is_div && !bus.funct3[0]
                     && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.rs2_data == {XLEN{1'b1}});
    assign w_special  = FAST_SPECIAL && (w_div0 || w_ovf);

    always_comb begin
        w_spec_res = w_is_rem ? bus.rs1_data : {XLEN{1'b1}};
        if (!w_div0) begin
            w_spec_res = w_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Multiply keeps the multiplier in the low half and shifts the sum in;
    // divide keeps the remainder high and the dividend/quotient low.
    assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]}
                    + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_dshift = r_acc[2*XLEN-1:XLEN-1];
    assign w_ddiff  = w_dshift - {1'b0, r_opd};

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_res = w_prod[XLEN-1:0];
        unique case (1'b1)
            (r_op[2] == 1'b0) && (r_op[1:0] != 2'b00):
                w_res = w_prod[2*XLEN-1:XLEN];
            (r_op[2:1] == 2'b10): w_res = w_quo;
            (r_op[2:1] == 2'b11): w_res = w_rem;
            default: w_res = w_prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == 5'd0) w_next = S_FIX;
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.funct3;
                        r_rd  <= bus.rd_addr;
                        r_cnt <= 5'd31;
                        // A zero divisor must leave the all-ones quotient unsigned.
                        r_neg <= w_is_rem ? w_sa : ((w_sa ^ w_sb) & ~w_div0);
                        r_opd <= w_is_div ? w_abs_b : w_abs_a;
                        r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                        if (w_special) r_result <= w_spec_res;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (!r_op[2]) begin
                        r_acc <= {w_msum, r_acc[XLEN-1:1]};
                    end else if (!w_ddiff[XLEN]) begin
                        r_acc <= {w_ddiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                    end else begin
                        r_acc <= {w_dshift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
                    end
                end
                S_FIX:   r_result <= w_res;
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.wb_en  = (r_state == S_DONE);
    assign bus.wb_rd  = r_rd;
    assign bus.result = r_result;
endmodule
